// File: rtl/bulk_mem_requester.sv
// Block-transfer master for the DDR controller bulk port: one 32-bit access
// per word over the request/align handshake, with write and read FIFOs.
module bulk_mem_requester #(
    parameter int FIFO_AW = 4,
    parameter int CNT_W   = 16
) (
    input  logic             CLK_n,
    input  logic             RST,
    input  logic             start,
    input  logic [25:0]      start_address,
    input  logic [CNT_W-1:0] word_count,
    input  logic             dir_write,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    input  logic [31:0]      wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [31:0]      rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [25:0]      bulk_req_address,
    output logic             bulk_req_we,
    output logic [3:0]       bulk_req_we_array,
    output logic             bulk_req,
    input  logic             bulk_req_ack,
    output logic             bulk_req_algn,
    input  logic             bulk_req_algn_ack,
    output logic [31:0]      bulk_req_datain,
    input  logic [31:0]      user_req_dataout
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_REQ,
        S_ALGN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [25:0]      r_addr;
    logic [CNT_W-1:0] r_remaining;
    logic             r_dirWrite;
    logic             r_aborted;
    logic             r_abortSeen;
    logic             r_zeroXfer;

    logic [31:0]        r_wrMem [DEPTH];
    logic [FIFO_AW-1:0] r_wrWrPtr;
    logic [FIFO_AW-1:0] r_wrRdPtr;
    logic [FIFO_AW:0]   r_wrCount;

    logic [31:0]        r_rdMem [DEPTH];
    logic [FIFO_AW-1:0] r_rdWrPtr;
    logic [FIFO_AW-1:0] r_rdRdPtr;
    logic [FIFO_AW:0]   r_rdCount;

    logic w_wrEmpty;
    logic w_wrFull;
    logic w_rdEmpty;
    logic w_rdFull;
    logic w_wrPush;
    logic w_wrPop;
    logic w_rdPush;
    logic w_rdPop;
    logic w_dataAck;
    logic w_gateOpen;
    logic w_zeroLeft;
    logic w_lastWord;

    assign w_wrEmpty  = (r_wrCount == '0);
    assign w_wrFull   = (r_wrCount == FULL_CNT);
    assign w_rdEmpty  = (r_rdCount == '0);
    assign w_rdFull   = (r_rdCount == FULL_CNT);
    assign w_dataAck  = (r_state == S_ALGN) && bulk_req_algn_ack;
    assign w_wrPush   = wr_valid && !w_wrFull;
    assign w_wrPop    = w_dataAck && r_dirWrite && !w_wrEmpty;
    assign w_rdPush   = w_dataAck && !r_dirWrite && !w_rdFull;
    assign w_rdPop    = rd_ready && !w_rdEmpty;
    assign w_gateOpen = r_dirWrite ? !w_wrEmpty : !w_rdFull;
    assign w_zeroLeft = (r_remaining == '0);
    assign w_lastWord = (r_remaining == CNT_W'(1));

    assign busy              = (r_state == S_WAIT) || (r_state == S_REQ) ||
                               (r_state == S_ALGN) ||
                               ((r_state == S_DONE) && !r_zeroXfer);
    assign done              = (r_state == S_DONE);
    assign aborted           = r_aborted;
    assign bulk_req          = (r_state == S_REQ);
    assign bulk_req_algn     = (r_state == S_ALGN);
    assign bulk_req_address  = r_addr;
    assign bulk_req_we       = r_dirWrite;
    assign bulk_req_we_array = {4{r_dirWrite}};
    assign bulk_req_datain   = r_wrMem[r_wrRdPtr];
    assign wr_ready          = !w_wrFull;
    assign rd_data           = r_rdMem[r_rdRdPtr];
    assign rd_valid          = !w_rdEmpty;

    // Write FIFO storage; contents need no reset because the count guards them.
    always_ff @(posedge CLK_n) begin
        if (w_wrPush) begin
            r_wrMem[r_wrWrPtr] <= wr_data;
        end
    end

    // Write FIFO pointers and occupancy, with simultaneous push and pop allowed.
    always_ff @(posedge CLK_n or posedge RST) begin
        if (RST) begin
            r_wrWrPtr <= '0;
            r_wrRdPtr <= '0;
            r_wrCount <= '0;
        end else begin
            if (w_wrPush) begin
                r_wrWrPtr <= r_wrWrPtr + 1'b1;
            end
            if (w_wrPop) begin
                r_wrRdPtr <= r_wrRdPtr + 1'b1;
            end
            case ({w_wrPush, w_wrPop})
                2'b10:   r_wrCount <= r_wrCount + 1'b1;
                2'b01:   r_wrCount <= r_wrCount - 1'b1;
                default: r_wrCount <= r_wrCount;
            endcase
        end
    end

    // Read FIFO storage, filled from the controller's read data on align ack.
    always_ff @(posedge CLK_n) begin
        if (w_rdPush) begin
            r_rdMem[r_rdWrPtr] <= user_req_dataout;
        end
    end

    // Read FIFO pointers and occupancy, drained by the consumer at any time.
    always_ff @(posedge CLK_n or posedge RST) begin
        if (RST) begin
            r_rdWrPtr <= '0;
            r_rdRdPtr <= '0;
            r_rdCount <= '0;
        end else begin
            if (w_rdPush) begin
                r_rdWrPtr <= r_rdWrPtr + 1'b1;
            end
            if (w_rdPop) begin
                r_rdRdPtr <= r_rdRdPtr + 1'b1;
            end
            case ({w_rdPush, w_rdPop})
                2'b10:   r_rdCount <= r_rdCount + 1'b1;
                2'b01:   r_rdCount <= r_rdCount - 1'b1;
                default: r_rdCount <= r_rdCount;
            endcase
        end
    end

    // Transfer state register.
    always_ff @(posedge CLK_n or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; a zero-length descriptor passes through WAIT so its
    // done pulse lands one cycle after busy, matching the normal latency.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_nextState = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_zeroLeft || abort) begin
                    w_nextState = S_DONE;
                end else if (w_gateOpen) begin
                    w_nextState = S_REQ;
                end
            end
            S_REQ: begin
                if (bulk_req_ack) begin
                    w_nextState = S_ALGN;
                end
            end
            S_ALGN: begin
                if (bulk_req_algn_ack) begin
                    if (w_lastWord || r_abortSeen || abort) begin
                        w_nextState = S_DONE;
                    end else begin
                        w_nextState = S_WAIT;
                    end
                end
            end
            S_DONE: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Descriptor, address/count progress and abort bookkeeping.
    always_ff @(posedge CLK_n or posedge RST) begin
        if (RST) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_dirWrite  <= 1'b0;
            r_aborted   <= 1'b0;
            r_abortSeen <= 1'b0;
            r_zeroXfer  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr      <= start_address;
                        r_remaining <= word_count;
                        r_dirWrite  <= dir_write;
                        r_aborted   <= 1'b0;
                        r_abortSeen <= 1'b0;
                        r_zeroXfer  <= (word_count == '0);
                    end
                end
                S_WAIT: begin
                    if (!w_zeroLeft && abort) begin
                        r_aborted <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (abort) begin
                        r_abortSeen <= 1'b1;
                    end
                end
                S_ALGN: begin
                    if (abort) begin
                        r_abortSeen <= 1'b1;
                    end
                    if (bulk_req_algn_ack) begin
                        r_addr      <= r_addr + 1'b1;
                        r_remaining <= r_remaining - 1'b1;
                        if (r_abortSeen || abort) begin
                            r_aborted <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bulk_mem_requester.sv
// Directed bench for bulk_mem_requester: the bench plays the DDR controller
// and the FIFO producer/consumer, with hand-computed expectations.
module tb_bulk_mem_requester;

    localparam int CNT_W = 16;

    logic             CLK_n = 1'b0;
    logic             RST;
    logic             start;
    logic [25:0]      start_address;
    logic [CNT_W-1:0] word_count;
    logic             dir_write;
    logic             abort;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [31:0]      wr_data;
    logic             wr_valid;
    logic             wr_ready;
    logic [31:0]      rd_data;
    logic             rd_valid;
    logic             rd_ready;
    logic [25:0]      bulk_req_address;
    logic             bulk_req_we;
    logic [3:0]       bulk_req_we_array;
    logic             bulk_req;
    logic             bulk_req_ack;
    logic             bulk_req_algn;
    logic             bulk_req_algn_ack;
    logic [31:0]      bulk_req_datain;
    logic [31:0]      user_req_dataout;

    int compared   = 0;
    int mismatched = 0;
    int doneCount  = 0;
    int reqCount   = 0;
    logic prevReq  = 1'b0;

    bulk_mem_requester #(.FIFO_AW(4), .CNT_W(CNT_W)) dut (
        .CLK_n             (CLK_n),
        .RST               (RST),
        .start             (start),
        .start_address     (start_address),
        .word_count        (word_count),
        .dir_write         (dir_write),
        .abort             (abort),
        .busy              (busy),
        .done              (done),
        .aborted           (aborted),
        .wr_data           (wr_data),
        .wr_valid          (wr_valid),
        .wr_ready          (wr_ready),
        .rd_data           (rd_data),
        .rd_valid          (rd_valid),
        .rd_ready          (rd_ready),
        .bulk_req_address  (bulk_req_address),
        .bulk_req_we       (bulk_req_we),
        .bulk_req_we_array (bulk_req_we_array),
        .bulk_req          (bulk_req),
        .bulk_req_ack      (bulk_req_ack),
        .bulk_req_algn     (bulk_req_algn),
        .bulk_req_algn_ack (bulk_req_algn_ack),
        .bulk_req_datain   (bulk_req_datain),
        .user_req_dataout  (user_req_dataout)
    );

    // Free-running clock.
    always #5 CLK_n = ~CLK_n;

    // Counts done pulses and issued requests, sampled mid-cycle.
    always @(negedge CLK_n) begin
        if (done) doneCount++;
        if (bulk_req && !prevReq) reqCount++;
        prevReq = bulk_req;
    end

    // Safety net so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLK_n);
        #1;
    endtask

    task automatic applyStimulus(input logic [25:0] addr, input logic [CNT_W-1:0] cnt,
                                 input logic dirW);
        start         = 1'b1;
        start_address = addr;
        word_count    = cnt;
        dir_write     = dirW;
        tick();
        start = 1'b0;
        checkOutput("busy after start", 32'(busy), 32'd1);
    endtask

    task automatic pushWord(input logic [31:0] d);
        wr_data  = d;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic popWord(input logic [31:0] expected);
        checkOutput("rd_valid before pop", 32'(rd_valid), 32'd1);
        checkOutput("rd_data", rd_data, expected);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    // Acts as the controller for one word: grant and data ack one cycle late.
    task automatic serveWord(input logic [25:0] expAddr, input logic expWe,
                             input logic [31:0] expWrData, input logic [31:0] rdWord,
                             input bit abortInAlgn);
        int waited = 0;
        while (!bulk_req && waited < 60) begin
            tick();
            waited++;
        end
        if (!bulk_req) begin
            checkOutput("bulk_req timeout", 32'(bulk_req), 32'd1);
            return;
        end
        checkOutput("req address", 32'(bulk_req_address), 32'(expAddr));
        checkOutput("req we", 32'(bulk_req_we), 32'(expWe));
        checkOutput("req we_array", 32'(bulk_req_we_array), expWe ? 32'hF : 32'h0);
        checkOutput("algn low during req", 32'(bulk_req_algn), 32'd0);
        tick();
        bulk_req_ack = 1'b1;
        tick();
        bulk_req_ack = 1'b0;
        checkOutput("req low in algn", 32'(bulk_req), 32'd0);
        checkOutput("algn high", 32'(bulk_req_algn), 32'd1);
        if (expWe) checkOutput("write data", bulk_req_datain, expWrData);
        if (abortInAlgn) abort = 1'b1;
        tick();
        abort             = 1'b0;
        user_req_dataout  = rdWord;
        bulk_req_algn_ack = 1'b1;
        tick();
        bulk_req_algn_ack = 1'b0;
        checkOutput("algn low after ack", 32'(bulk_req_algn), 32'd0);
    endtask

    task automatic checkDone(input logic expAborted);
        checkOutput("done pulse", 32'(done), 32'd1);
        checkOutput("aborted", 32'(aborted), 32'(expAborted));
        checkOutput("busy during done", 32'(busy), 32'd1);
        tick();
        checkOutput("done cleared", 32'(done), 32'd0);
        checkOutput("busy cleared", 32'(busy), 32'd0);
    endtask

    initial begin
        logic reqSeen;
        int   reqBase;
        int   doneBase;

        RST = 1'b1;
        start = 1'b0; start_address = '0; word_count = '0; dir_write = 1'b0;
        abort = 1'b0; wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;
        bulk_req_ack = 1'b0; bulk_req_algn_ack = 1'b0; user_req_dataout = '0;
        tick();
        tick();
        RST = 1'b0;
        tick();

        $display("[TB] reset values");
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset aborted", 32'(aborted), 32'd0);
        checkOutput("reset bulk_req", 32'(bulk_req), 32'd0);
        checkOutput("reset algn", 32'(bulk_req_algn), 32'd0);
        checkOutput("reset we", 32'(bulk_req_we), 32'd0);
        checkOutput("reset we_array", 32'(bulk_req_we_array), 32'd0);
        checkOutput("reset address", 32'(bulk_req_address), 32'd0);
        checkOutput("reset wr_ready", 32'(wr_ready), 32'd1);
        checkOutput("reset rd_valid", 32'(rd_valid), 32'd0);

        $display("[TB] write 4 words at 0x100");
        for (int i = 0; i < 4; i++) pushWord(32'hD000_0000 + 32'(i));
        applyStimulus(26'h0000100, 16'd4, 1'b1);
        for (int i = 0; i < 4; i++)
            serveWord(26'h0000100 + 26'(i), 1'b1, 32'hD000_0000 + 32'(i), 32'h0, 1'b0);
        checkDone(1'b0);

        $display("[TB] read 3 words across the address wrap");
        applyStimulus(26'h3FFFFFE, 16'd3, 1'b0);
        serveWord(26'h3FFFFFE, 1'b0, 32'h0, 32'hA0, 1'b0);
        serveWord(26'h3FFFFFF, 1'b0, 32'h0, 32'hA1, 1'b0);
        serveWord(26'h0000000, 1'b0, 32'h0, 32'hA2, 1'b0);
        checkDone(1'b0);
        popWord(32'hA0);
        popWord(32'hA1);
        popWord(32'hA2);
        checkOutput("rd fifo drained", 32'(rd_valid), 32'd0);

        $display("[TB] write 5 words with late producer");
        applyStimulus(26'h0000200, 16'd5, 1'b1);
        reqSeen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            reqSeen = reqSeen | bulk_req;
        end
        checkOutput("no req while wr fifo empty", 32'(reqSeen), 32'd0);
        checkOutput("busy while stalled", 32'(busy), 32'd1);
        for (int i = 0; i < 5; i++) pushWord(32'hE000_0000 + 32'(i));
        for (int i = 0; i < 5; i++)
            serveWord(26'h0000200 + 26'(i), 1'b1, 32'hE000_0000 + 32'(i), 32'h0, 1'b0);
        checkDone(1'b0);

        $display("[TB] read 20 words with stalled consumer");
        reqBase  = reqCount;
        doneBase = doneCount;
        applyStimulus(26'h0000300, 16'd20, 1'b0);
        for (int i = 0; i < 16; i++)
            serveWord(26'h0000300 + 26'(i), 1'b0, 32'h0, 32'h0000_0B00 + 32'(i), 1'b0);
        reqSeen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            reqSeen = reqSeen | bulk_req;
        end
        checkOutput("no req while rd fifo full", 32'(reqSeen), 32'd0);
        checkOutput("16 accesses before stall", 32'(reqCount - reqBase), 32'd16);
        checkOutput("busy while rd stalled", 32'(busy), 32'd1);
        checkOutput("wr_ready unaffected", 32'(wr_ready), 32'd1);
        for (int i = 0; i < 4; i++) popWord(32'h0000_0B00 + 32'(i));
        for (int i = 16; i < 20; i++)
            serveWord(26'h0000300 + 26'(i), 1'b0, 32'h0, 32'h0000_0B00 + 32'(i), 1'b0);
        checkDone(1'b0);
        checkOutput("one done for 20-word read", 32'(doneCount - doneBase), 32'd1);
        for (int i = 4; i < 20; i++) popWord(32'h0000_0B00 + 32'(i));
        checkOutput("rd fifo drained after 20", 32'(rd_valid), 32'd0);

        $display("[TB] abort during word 2 of 8-word write");
        for (int i = 0; i < 8; i++) pushWord(32'h0000_0C00 + 32'(i));
        reqBase = reqCount;
        applyStimulus(26'h0000400, 16'd8, 1'b1);
        serveWord(26'h0000400, 1'b1, 32'h0000_0C00, 32'h0, 1'b0);
        serveWord(26'h0000401, 1'b1, 32'h0000_0C01, 32'h0, 1'b1);
        checkDone(1'b1);
        reqSeen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            reqSeen = reqSeen | bulk_req;
        end
        checkOutput("no req after abort", 32'(reqSeen), 32'd0);
        checkOutput("two accesses before abort", 32'(reqCount - reqBase), 32'd2);
        checkOutput("aborted holds", 32'(aborted), 32'd1);
        checkOutput("wr fifo head after abort", bulk_req_datain, 32'h0000_0C02);
        for (int i = 0; i < 9; i++) pushWord(32'h0000_0F00 + 32'(i));
        checkOutput("wr_ready with 15 words", 32'(wr_ready), 32'd1);
        pushWord(32'h0000_0F09);
        checkOutput("wr_ready with 16 words", 32'(wr_ready), 32'd0);

        RST = 1'b1;
        tick();
        checkOutput("reset clears wr fifo", 32'(wr_ready), 32'd1);
        checkOutput("reset clears aborted", 32'(aborted), 32'd0);
        RST = 1'b0;
        tick();

        $display("[TB] zero-length descriptor");
        reqBase = reqCount;
        applyStimulus(26'h0000500, 16'd0, 1'b1);
        checkOutput("zero no done at T+1", 32'(done), 32'd0);
        tick();
        checkOutput("zero done at T+2", 32'(done), 32'd1);
        checkOutput("zero busy at T+2", 32'(busy), 32'd0);
        tick();
        checkOutput("zero done cleared", 32'(done), 32'd0);
        checkOutput("zero no req", 32'(reqCount - reqBase), 32'd0);

        $display("[TB] reset during REQ");
        pushWord(32'h1234_5678);
        doneBase = doneCount;
        applyStimulus(26'h0000600, 16'd1, 1'b1);
        for (int i = 0; i < 20 && !bulk_req; i++) tick();
        checkOutput("req before reset", 32'(bulk_req), 32'd1);
        #2;
        RST = 1'b1;
        #1;
        checkOutput("async reset req", 32'(bulk_req), 32'd0);
        checkOutput("async reset busy", 32'(busy), 32'd0);
        checkOutput("async reset wr fifo", 32'(wr_ready), 32'd1);
        tick();
        RST = 1'b0;
        tick();
        tick();
        checkOutput("no done from reset", 32'(doneCount - doneBase), 32'd0);
        checkOutput("idle after reset", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
